// File: rtl/alu_lab_pkg.sv
// Shared constants and types for the lab ALU result-register stage.
// Holds width defaults, the history pointer width and the capture FSM state type.
package alu_lab_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int HIST_DEPTH_DEF = 4;

    // Pointer width for a history ring; a depth of 1 still needs a 1-bit select.
    function automatic int ptr_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    localparam int HIST_PTR_W = ptr_width(HIST_DEPTH_DEF);

    localparam logic [DATA_W_DEF-1:0] REG_RESET = '0;

    typedef enum logic {
        CAP_IDLE  = 1'b0,
        CAP_ARMED = 1'b1
    } cap_state_t;

endpackage

// File: rtl/alu_result_reg_if.sv
// Bus between the ALU/board side (master) and the result register stage (slave).
interface alu_result_reg_if
    import alu_lab_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int HIST_DEPTH = HIST_DEPTH_DEF
);
    localparam int PTR_W = ptr_width(HIST_DEPTH);

    logic [DATA_W-1:0] result;
    logic              capture_req;
    logic              hold;
    logic              clear;
    logic [DATA_W-1:0] register;
    logic [7:0]        cap_count;
    logic [PTR_W-1:0]  hist_sel;
    logic [DATA_W-1:0] hist_out;
    logic              hist_valid;

    modport master (
        output result, capture_req, hold, clear, hist_sel,
        input  register, cap_count, hist_out, hist_valid
    );

    modport slave (
        input  result, capture_req, hold, clear, hist_sel,
        output register, cap_count, hist_out, hist_valid
    );

endinterface

// File: rtl/rise_detect.sv
// Registered rising-edge detector for level inputs such as debounced KEYs.
// Fires on the IDLE->ARMED transition only; re-arms once the input returns low.
module rise_detect
    import alu_lab_pkg::*;
(
    input  logic Clock,
    input  logic Reset_b,
    input  logic in,
    output logic pulse
);

    cap_state_t state_reg;
    cap_state_t state_next;

    always_ff @(posedge Clock) begin
        if (!Reset_b) begin
            state_reg <= CAP_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pulse      = 1'b0;
        case (state_reg)
            CAP_IDLE: begin
                if (in) begin
                    pulse      = 1'b1;
                    state_next = CAP_ARMED;
                end
            end
            CAP_ARMED: begin
                if (!in) begin
                    state_next = CAP_IDLE;
                end
            end
            default: state_next = CAP_IDLE;
        endcase
    end

endmodule

// File: rtl/alu_result_reg.sv
// Feedback register for the lab ALU with capture counter and optional history ring.
// Define ALU_RESULT_REG_HISTORY_EN to build the HIST_DEPTH-entry history.
module alu_result_reg
    import alu_lab_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int HIST_DEPTH = HIST_DEPTH_DEF
)(
    input  logic              Clock,
    input  logic              Reset_b,
    alu_result_reg_if.slave   bus
);

    localparam int PTR_W = ptr_width(HIST_DEPTH);

    logic              cap_pulse;
    logic              accept;
    logic [DATA_W-1:0] register_reg;
    logic [7:0]        cap_count_reg;

    rise_detect u_rise (
        .Clock   (Clock),
        .Reset_b (Reset_b),
        .in      (bus.capture_req),
        .pulse   (cap_pulse)
    );

    // A pulse blocked by hold or clear is still consumed by the detector.
    assign accept = cap_pulse & ~bus.hold & ~bus.clear;

    always_ff @(posedge Clock) begin
        if (!Reset_b) begin
            register_reg  <= DATA_W'(REG_RESET);
            cap_count_reg <= '0;
        end else begin
            if (bus.clear) begin
                register_reg <= '0;
            end else if (accept) begin
                register_reg <= bus.result;
            end
            if (accept) begin
                cap_count_reg <= cap_count_reg + 8'd1;
            end
        end
    end

    assign bus.register  = register_reg;
    assign bus.cap_count = cap_count_reg;

`ifdef ALU_RESULT_REG_HISTORY_EN
    logic [PTR_W-1:0]  wp_reg;
    logic [PTR_W-1:0]  wp_next;
    logic [PTR_W-1:0]  rd_idx;
    logic [DATA_W-1:0] hist_reg       [HIST_DEPTH];
    logic              hist_valid_reg [HIST_DEPTH];

    assign wp_next = wp_reg + PTR_W'(1);

    // Starting at the last slot makes the first capture land in entry 0.
    always_ff @(posedge Clock) begin
        if (!Reset_b) begin
            wp_reg <= PTR_W'(HIST_DEPTH - 1);
        end else if (accept) begin
            wp_reg <= wp_next;
        end
    end

    generate
        for (genvar gi = 0; gi < HIST_DEPTH; gi++) begin : g_hist
            always_ff @(posedge Clock) begin
                if (!Reset_b) begin
                    hist_reg[gi]       <= '0;
                    hist_valid_reg[gi] <= 1'b0;
                end else if (accept && (wp_next == PTR_W'(gi))) begin
                    hist_reg[gi]       <= bus.result;
                    hist_valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    // Power-of-two depth lets the pointer subtraction wrap naturally.
    assign rd_idx         = wp_reg - bus.hist_sel;
    assign bus.hist_out   = hist_reg[rd_idx];
    assign bus.hist_valid = hist_valid_reg[rd_idx];
`else
    logic any_cap_reg;
    logic unused_hist_sel;

    always_ff @(posedge Clock) begin
        if (!Reset_b) begin
            any_cap_reg <= 1'b0;
        end else if (accept) begin
            any_cap_reg <= 1'b1;
        end
    end

    assign unused_hist_sel = ^bus.hist_sel;
    assign bus.hist_out    = register_reg;
    assign bus.hist_valid  = any_cap_reg;
`endif

endmodule

// File: tb/tb_alu_result_reg.sv
// Directed scoreboard bench for alu_result_reg; history checks adapt to ALU_RESULT_REG_HISTORY_EN.
module tb_alu_result_reg;

    logic clk;
    logic rst_b;

    alu_result_reg_if bus ();

    alu_result_reg dut (
        .Clock   (clk),
        .Reset_b (rst_b),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] reg_v;
        logic [7:0] cnt;
        logic [7:0] hout;
        logic       hv;
    } exp_t;

    exp_t  exp_q  [$];
    string name_q [$];
    int    checks = 0;
    int    errors = 0;
    logic  any_cap;

    // Monitor: drains queued expectations against DUT outputs on each falling edge.
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if (bus.register !== e.reg_v) begin
                    errors++;
                    $display("FAIL %s register got %02h want %02h", n, bus.register, e.reg_v);
                end
                checks++;
                if (bus.cap_count !== e.cnt) begin
                    errors++;
                    $display("FAIL %s cap_count got %0d want %0d", n, bus.cap_count, e.cnt);
                end
                checks++;
                if (bus.hist_out !== e.hout) begin
                    errors++;
                    $display("FAIL %s hist_out got %02h want %02h", n, bus.hist_out, e.hout);
                end
                checks++;
                if (bus.hist_valid !== e.hv) begin
                    errors++;
                    $display("FAIL %s hist_valid got %b want %b", n, bus.hist_valid, e.hv);
                end
                $display("check %-14s sel=%0d reg=%02h cnt=%0d hist=%02h/%b", n, bus.hist_sel,
                         bus.register, bus.cap_count, bus.hist_out, bus.hist_valid);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push an expectation; hh/hv apply to the history build, else the register mirror is expected.
    task automatic chk(input string n, input logic [7:0] r, input logic [7:0] c,
                       input logic [7:0] hh, input logic hv);
        exp_t e;
        e.reg_v = r;
        e.cnt   = c;
`ifdef ALU_RESULT_REG_HISTORY_EN
        e.hout  = hh;
        e.hv    = hv;
`else
        e.hout  = r;
        e.hv    = any_cap;
`endif
        exp_q.push_back(e);
        name_q.push_back(n);
        @(negedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] v);
        bus.result      = v;
        bus.capture_req = 1'b1;
        tick();
        bus.capture_req = 1'b0;
        tick();
        any_cap = 1'b1;
    endtask

    initial begin
        rst_b           = 1'b0;
        bus.result      = 8'h00;
        bus.capture_req = 1'b0;
        bus.hold        = 1'b0;
        bus.clear       = 1'b0;
        bus.hist_sel    = '0;
        any_cap         = 1'b0;

        tick();
        tick();
        chk("reset", 8'h00, 8'd0, 8'h00, 1'b0);
        rst_b = 1'b1;
        tick();

        // Single capture held for 10 cycles.
        bus.result      = 8'h1F;
        bus.capture_req = 1'b1;
        tick();
        any_cap = 1'b1;
        chk("single", 8'h1F, 8'd1, 8'h1F, 1'b1);
        bus.result = 8'h55;
        repeat (9) tick();
        chk("single_held", 8'h1F, 8'd1, 8'h1F, 1'b1);
        bus.capture_req = 1'b0;
        tick();

        press(8'h01);
        press(8'h02);
        press(8'h03);
        press(8'h04);
        bus.hist_sel = 2'd0; chk("four_sel0", 8'h04, 8'd5, 8'h04, 1'b1);
        bus.hist_sel = 2'd1; chk("four_sel1", 8'h04, 8'd5, 8'h03, 1'b1);
        bus.hist_sel = 2'd2; chk("four_sel2", 8'h04, 8'd5, 8'h02, 1'b1);
        bus.hist_sel = 2'd3; chk("four_sel3", 8'h04, 8'd5, 8'h01, 1'b1);

        press(8'h05);
        bus.hist_sel = 2'd3; chk("wrap_sel3", 8'h05, 8'd6, 8'h02, 1'b1);
        bus.hist_sel = 2'd0; chk("wrap_sel0", 8'h05, 8'd6, 8'h05, 1'b1);

        // Hold on the edge consumes it; dropping hold later must not capture.
        bus.hold        = 1'b1;
        bus.result      = 8'hAA;
        bus.capture_req = 1'b1;
        tick();
        chk("hold_edge", 8'h05, 8'd6, 8'h05, 1'b1);
        bus.hold = 1'b0;
        tick();
        chk("hold_release", 8'h05, 8'd6, 8'h05, 1'b1);
        bus.capture_req = 1'b0;
        tick();

        // Clear wins over a simultaneous edge.
        bus.clear       = 1'b1;
        bus.result      = 8'hBB;
        bus.capture_req = 1'b1;
        tick();
        chk("clear_edge", 8'h00, 8'd6, 8'h05, 1'b1);
        bus.clear = 1'b0;
        tick();
        chk("clear_after", 8'h00, 8'd6, 8'h05, 1'b1);
        bus.capture_req = 1'b0;
        tick();

        // 250 more accepted captures bring the total to 256.
        for (int i = 1; i <= 250; i++) begin
            press(8'(i));
        end
        chk("cnt_wrap", 8'hFA, 8'd0, 8'hFA, 1'b1);

        // Reset during an accepting cycle, then request held through deassertion.
        bus.result      = 8'h77;
        bus.capture_req = 1'b1;
        rst_b           = 1'b0;
        tick();
        any_cap = 1'b0;
        chk("reset_accept", 8'h00, 8'd0, 8'h00, 1'b0);
        rst_b = 1'b1;
        tick();
        any_cap = 1'b1;
        chk("post_reset_cap", 8'h77, 8'd1, 8'h77, 1'b1);
        repeat (3) tick();
        chk("post_reset_held", 8'h77, 8'd1, 8'h77, 1'b1);
        bus.hist_sel = 2'd1;
        chk("post_reset_sel1", 8'h77, 8'd1, 8'h00, 1'b0);
        bus.capture_req = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_reg.md
# alu_result_reg

Result register stage directly downstream of the 4-bit lab ALU. Captures the ALU's 8-bit `result` into the feedback register on a rising edge of a capture request, and drives `register` back to the ALU's `register` input, closing the accumulate loop. Also keeps a capture counter and a 4-entry history of recent captures for display on HEX/LEDR.

## Interface
Parameters:
- `DATA_W`, 8: result/register width; must match the ALU output.
- `HIST_DEPTH`, 4: history entries; power of two, at least 2.

Ports:
- `Clock`  in  1: the block's single clock.
- `Reset_b`  in  1: synchronous, active-low reset, sampled on the rising edge of `Clock`.
- `result`  in  DATA_W: combinational ALU output.
- `capture_req`  in  1: active-high capture request (board KEY already inverted). Level input; may be held for many cycles.
- `hold`  in  1: when high, captures are suppressed.
- `clear`  in  1: synchronous clear of `register` only.
- `register`  out  DATA_W: captured value, fed back to the ALU.
- `cap_count`  out  8: number of accepted captures, modulo 256.
- `hist_sel`  in  log2(HIST_DEPTH): 0 selects the newest history entry, 1 the next older, and so on.
- `hist_out`  out  DATA_W: the selected history entry (combinational).
- `hist_valid`  out  1: the selected entry has been written since reset.

## Operation
- Edge detect: `cap_q` registers `capture_req` each cycle. `cap_pulse = capture_req & ~cap_q`.
- Accept: `accept = cap_pulse & ~hold & ~clear`.
- On `accept`:
  - `register <= result`.
  - `cap_count <= cap_count + 1`, wrapping 255 → 0.
  - The history write pointer `wp` advances and `result` is written at the new position.
- `clear` high: `register <= 0`. Counter and history are unchanged. If `clear` and `cap_pulse` occur in the same cycle, `clear` wins and the edge is consumed, so there is no capture later.
- `hold` high during the edge: the edge is consumed and is not retried when `hold` drops. The user must release and re-press.
- History read: `hist_out = hist[(wp - hist_sel) mod HIST_DEPTH]`.
  - `hist_valid` is the per-entry written bit at that index.
  - Unwritten entries read 0.
- Ring wrap: the fifth capture overwrites the oldest entry. All valid bits remain 1.
- Two-state sequencing per press: IDLE (`cap_q = 0`) → ARMED (`cap_q = 1`, waiting for release) → IDLE on `capture_req = 0`. Only the IDLE→ARMED transition can accept.

## Timing
- Reset (`Reset_b = 0` at a rising edge) sets:
  - `register` = 0, `cap_count` = 0, `cap_q` = 0, `wp` = HIST_DEPTH-1.
  - All history entries = 0 and all valid bits = 0. Hence `hist_out` = 0 and `hist_valid` = 0.
- Reset dominates `accept` and `clear` in the same cycle.
- If `capture_req` is held high through the deassertion of reset, the first cycle after reset sees `cap_q = 0`, so that cycle produces an edge.
- Capture latency: `register` shows `result` one rising edge after the first cycle in which `capture_req` is sampled high.
- Since `result` depends combinationally on `register`, the value captured is the ALU output during the accepting cycle. The new `register` value is visible to the ALU the following cycle.
- Holding `capture_req` high yields exactly one capture, regardless of duration.
- The minimum spacing between captures is 2 cycles (the request must go low for at least 1 cycle).
- `hist_out` and `hist_valid` are combinational from `hist_sel` and state, with no read latency.

## Configuration
- Macro: `ALU_RESULT_REG_HISTORY_EN`.
- Defined: history ring, `wp`, valid bits and the history read path are built as described above.
- Undefined: no history storage is built.
  - `hist_out = register`.
  - `hist_valid = 1` once any capture has been accepted since reset, otherwise 0.
  - `hist_sel` is ignored.
  - `register`, `cap_count` and edge behaviour are identical in both builds.

## Structure
- Shared package `alu_lab_pkg` holds:
  - `DATA_W` default (8) and `HIST_DEPTH` default (4).
  - The history pointer width, log2(HIST_DEPTH).
  - The reset constant for `register` (all zeros).
- One sub-module, `rise_detect`: a registered rising-edge detector (`Clock`, `Reset_b`, `in`, `pulse`). It is reusable for other KEY-driven stages.
- History is a flop array, not inferred RAM, to keep the combinational read.

## Test plan
- **Reset:** `Reset_b = 0` for 2 cycles → `register` = 0x00, `cap_count` = 0, `hist_valid` = 0, `hist_out` = 0x00.
- **Single capture:** `result` = 0x1F, `capture_req` high for 10 cycles → `register` = 0x1F after exactly 1 edge, `cap_count` = 1. No further change while held.
- **Four captures:** captures of 0x01, 0x02, 0x03, 0x04 → `hist_sel` 0..3 read 0x04, 0x03, 0x02, 0x01, all with `hist_valid` = 1.
- **Wrap:** a fifth capture of 0x05 → `hist_sel` 3 reads 0x02.
- **Counter wrap:** 256 accepted captures → `cap_count` returns to 0.
- **Contention:**
  - `hold` high on the edge → `register` unchanged and `cap_count` unchanged. Dropping `hold` while the request is still high causes no capture.
  - `clear` and the edge in the same cycle → `register` = 0x00, `cap_count` unchanged.
  - `Reset_b` low during an accepting cycle → all outputs at reset values.
  - `capture_req` held through reset deassertion → exactly one capture on the first post-reset cycle.
